// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcode/funct constants, instruction field
// positions and the state encoding of the mult/div busy tracker.
package mips_defs;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_decode.sv
// Combinational ID-stage operand-usage decode. Reports which source
// registers an instruction reads and whether it touches HI/LO or starts
// a mult/div. Shared with the forwarding-select logic.
module hazard_decode
  import mips_defs::*;
(
  input  logic [31:0] instr_i,
  output logic        uses_rs_o,
  output logic        uses_rt_o,
  output logic        is_hilo_o,
  output logic        is_md_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign op    = instr_i[OP_MSB:OP_LSB];
  assign funct = instr_i[FN_MSB:FN_LSB];
  assign rs_o  = instr_i[RS_MSB:RS_LSB];
  assign rt_o  = instr_i[RT_MSB:RT_LSB];

  // rd/shamt/immediate bits play no part in hazard decisions
  assign unused_instr_bits = ^instr_i[15:6];

  // Classify the ID instruction by opcode and funct
  always_comb begin
    uses_rs_o = 1'b1;
    uses_rt_o = 1'b0;
    is_hilo_o = 1'b0;
    is_md_o   = 1'b0;
    case (op)
      OP_J, OP_JAL, OP_LUI: uses_rs_o = 1'b0;
      default:              uses_rs_o = 1'b1;
    endcase
    case (op)
      OP_SPECIAL, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: uses_rt_o = 1'b1;
      default:                                         uses_rt_o = 1'b0;
    endcase
    if (op == OP_SPECIAL) begin
      case (funct)
        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO:   is_hilo_o = 1'b1;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:   is_md_o   = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble controller beside the ID stage. Catches load-use hazards
// that forwarding cannot cover, holds HI/LO readers and new mult/div ops
// while the multi-cycle unit is busy, and applies the data-memory freeze.
// Optional feature: define HAZARD_PERF_EN to add the 32-bit stall_cycles
// counter and port.
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic        ex_regwr,
  input  logic        ex_memrd,
  input  logic [4:0]  ex_regdst_addr,
  input  logic        mem_wait,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic        muldiv_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       uses_rs;
  logic       uses_rt;
  logic       is_hilo;
  logic       is_md;
  logic [4:0] rs;
  logic [4:0] rt;

  logic       load_use;
  logic       md_hold;
  logic       hz;
  logic       issue;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  hazard_decode u_decode (
    .instr_i   (id_instr),
    .uses_rs_o (uses_rs),
    .uses_rt_o (uses_rt),
    .is_hilo_o (is_hilo),
    .is_md_o   (is_md),
    .rs_o      (rs),
    .rt_o      (rt)
  );

  // A load in EX has no data yet; a single bubble lets it reach MEM where
  // forwarding takes over. Register $0 is hardwired and never hazards.
  assign load_use = ex_regwr & ex_memrd & (ex_regdst_addr != 5'd0) &
                    ((uses_rs & (rs == ex_regdst_addr)) |
                     (uses_rt & (rt == ex_regdst_addr)));

  assign muldiv_busy = (state_q == MD_BUSY);
  assign md_hold     = muldiv_busy & (is_hilo | is_md);
  assign hz          = load_use | md_hold;
  assign issue       = is_md & ~hz & ~mem_wait;

  // Pipeline control; the memory freeze dominates any hazard bubble
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (mem_wait) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (hz) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // Busy tracker next state; the unit keeps counting through memory freezes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (issue) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy tracker state; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_q, stall_d;

  assign stall_d      = pc_stall ? (stall_q + 32'd1) : stall_q;
  assign stall_cycles = stall_q;

  // Count every cycle the PC is held; wraps naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule
